psum_accumulator: RTL and testbench

Output stage that sits directly downstream of the last processing element in a PE column. It consumes the registered partial sum that leaves the column once per input tile. It accumulates `TILES` consecutive partial sums into one dot-product result, then shifts, rectifies and saturates that result to activation width. Finished results are buffered in a small FIFO with a valid/ready output handshake toward the activation buffer.

---
 rtl/pe_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/psum_accumulator.sv | 92 +++++++++
 tb/tb_psum_accumulator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE-array package: default datapath widths plus the clog2 and
// signed-saturation helpers used by the column output stages.
package pe_pkg;

  localparam int BW_IN  = 16;
  localparam int BW_ACC = 20;
  localparam int BW_OUT = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1)
      r++;
    return r;
  endfunction

  // Clamp v into the signed range of a bw-bit value (bw in 2..63).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                   input int unsigned bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; reads the head combinationally
// and presents zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  wdata,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  rdata,
  output logic [pe_pkg::clog2(DEPTH):0]     count
);

  localparam int PW = pe_pkg::clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// PE-column output stage: sums TILES partial sums per result, then shifts,
// rectifies and saturates to activation width into a valid/ready FIFO.
module psum_accumulator #(
  parameter int BW_IN  = pe_pkg::BW_IN,
  parameter int BW_ACC = pe_pkg::BW_ACC,
  parameter int BW_OUT = pe_pkg::BW_OUT,
  parameter int TILES  = 4,
  parameter int SHIFT  = 2,
  parameter int RELU   = 1,
  parameter int DEPTH  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic signed [BW_IN-1:0]        i_psum,
  input  logic                           i_clear,
  output logic                           o_ready,
  output logic                           o_valid,
  output logic signed [BW_OUT-1:0]       o_data,
  input  logic                           i_ready,
  output logic [pe_pkg::clog2(TILES):0]  o_tile_cnt
);

  import pe_pkg::sat_signed;

  localparam int CW = pe_pkg::clog2(TILES) + 1;
  localparam int AW = pe_pkg::clog2(DEPTH) + 1;

  logic signed [BW_ACC-1:0] acc;
  logic signed [BW_ACC-1:0] sum;
  logic signed [BW_ACC-1:0] shifted;
  logic signed [63:0]       clipped;
  logic [BW_OUT-1:0]        res;
  logic [CW-1:0]            cnt;
  logic [AW-1:0]            fifo_count;
  logic [BW_OUT-1:0]        head;
  logic                     accept;
  logic                     last;
  logic                     push;

  assign o_ready    = (fifo_count < AW'(DEPTH));
  assign o_valid    = (fifo_count != '0);
  assign o_data     = head;
  assign o_tile_cnt = cnt;

  assign accept = i_valid && o_ready;
  assign last   = (cnt == CW'(TILES - 1));
  assign push   = accept && last && !i_clear;

  assign sum     = acc + BW_ACC'(i_psum);
  assign shifted = sum >>> SHIFT;

  always_comb begin
    clipped = sat_signed(64'(shifted), BW_OUT);
    if (RELU != 0 && shifted < 0)
      clipped = '0;
    res = clipped[BW_OUT-1:0];
  end

  // Clear wins over a beat presented in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (i_clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (BW_OUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .wdata (res),
    .pop   (o_valid && i_ready),
    .rdata (head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator; a second instance with RELU=0 shares
// the same stimulus so signed pass-through results are checked alongside.
module tb_psum_accumulator;

  logic              clk;
  logic              rst;
  logic              valid;
  logic signed [15:0] psum;
  logic              clear;
  logic              ready;
  logic              o_ready, o_valid;
  logic signed [7:0] o_data;
  logic [2:0]        tile_cnt;
  logic              n_ready, n_valid;
  logic signed [7:0] n_data;
  logic [2:0]        n_tile_cnt;

  int total = 0;
  int bad   = 0;

  psum_accumulator u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_psum(psum), .i_clear(clear),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(ready),
    .o_tile_cnt(tile_cnt)
  );

  psum_accumulator #(.RELU(0)) u_nr (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_psum(psum), .i_clear(clear),
    .o_ready(n_ready), .o_valid(n_valid), .o_data(n_data), .i_ready(ready),
    .o_tile_cnt(n_tile_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [15:0] v);
    valid = 1'b1;
    psum  = v;
    step();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; psum = '0; clear = 1'b0; ready = 1'b0;
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    total++; if (o_data !== 8'sd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", o_data); end
    total++; if (tile_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", tile_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic signed [15:0] vals [4];
    vals = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      beat(vals[k]);
      total++;
      if (tile_cnt !== 3'((k + 1) % 4)) begin
        bad++; $display("FAIL basic_cnt%0d got=%0d exp=%0d", k, tile_cnt, (k + 1) % 4);
      end
      if (k < 3) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid%0d got=%0b exp=0", k, o_valid); end
      end
    end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", o_valid); end
    total++; if (o_data !== 8'sd25) begin bad++; $display("FAIL basic_data got=%0d exp=25", o_data); end
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_pop got=%0b exp=0", o_valid); end
  endtask

  task automatic test_relu();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(-16'sd5);
    total++; if (o_data !== 8'sd0) begin bad++; $display("FAIL relu_data got=%0d exp=0", o_data); end
    total++; if (n_data !== -8'sd5) begin bad++; $display("FAIL norelu_data got=%0d exp=-5", n_data); end
    ready = 1'b1;
    step();
  endtask

  task automatic test_sat();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(16'sd32767);
    total++; if (o_data !== 8'sd127) begin bad++; $display("FAIL sat_pos got=%0d exp=127", o_data); end
    total++; if (n_data !== 8'sd127) begin bad++; $display("FAIL sat_pos_nr got=%0d exp=127", n_data); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(-16'sd32768);
    total++; if (n_data !== -8'sd128) begin bad++; $display("FAIL sat_neg_nr got=%0d exp=-128", n_data); end
    total++; if (o_data !== 8'sd0) begin bad++; $display("FAIL sat_neg_relu got=%0d exp=0", o_data); end
    ready = 1'b1;
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL sat_drain got=%0b exp=0", o_valid); end
  endtask

  task automatic test_backpressure();
    int acc_beats;
    int got;
    logic fire_in;
    logic fire_out;
    ready = 1'b0;
    valid = 1'b1;
    psum  = 16'sd4;
    repeat (15) step();
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_before_full got=%0b exp=1", o_ready); end
    step();
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%0b exp=0", o_ready); end
    repeat (3) step();
    total++; if (tile_cnt !== 3'd0) begin bad++; $display("FAIL bp_stalled_cnt got=%0d exp=0", tile_cnt); end
    total++; if (o_data !== 8'sd4) begin bad++; $display("FAIL bp_stable_data got=%0d exp=4", o_data); end
    ready = 1'b1;
    acc_beats = 0;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      valid = (acc_beats < 4);
      fire_in  = valid && o_ready;
      fire_out = o_valid && ready;
      if (fire_out) begin
        got++;
        total++; if (o_data !== 8'sd4) begin bad++; $display("FAIL bp_data%0d got=%0d exp=4", got, o_data); end
      end
      step();
      if (fire_in) acc_beats++;
    end
    valid = 1'b0;
    total++; if (got != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", got); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b exp=0", o_valid); end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(16'sd4);
    beat(16'sd100);
    beat(16'sd100);
    total++; if (tile_cnt !== 3'd2) begin bad++; $display("FAIL rm_cnt_before got=%0d exp=2", tile_cnt); end
    rst = 1'b1;
    #2;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rm_valid_in_reset got=%0b exp=0", o_valid); end
    total++; if (tile_cnt !== 3'd0) begin bad++; $display("FAIL rm_cnt_in_reset got=%0d exp=0", tile_cnt); end
    #1;
    rst = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) beat(16'sd4);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rm_no_early got=%0b exp=0", o_valid); end
    beat(16'sd4);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rm_valid got=%0b exp=1", o_valid); end
    total++; if (o_data !== 8'sd4) begin bad++; $display("FAIL rm_data got=%0d exp=4", o_data); end
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rm_single got=%0b exp=0", o_valid); end
  endtask

  task automatic test_clear();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(16'sd12);
    for (int k = 0; k < 3; k++) beat(16'sd50);
    total++; if (tile_cnt !== 3'd3) begin bad++; $display("FAIL clr_cnt_before got=%0d exp=3", tile_cnt); end
    clear = 1'b1;
    beat(16'sd50);
    clear = 1'b0;
    total++; if (tile_cnt !== 3'd0) begin bad++; $display("FAIL clr_cnt_after got=%0d exp=0", tile_cnt); end
    total++; if (o_data !== 8'sd12) begin bad++; $display("FAIL clr_retained got=%0d exp=12", o_data); end
    for (int k = 0; k < 4; k++) beat(16'sd8);
    total++; if (o_data !== 8'sd12) begin bad++; $display("FAIL clr_head got=%0d exp=12", o_data); end
    ready = 1'b1;
    step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL clr_second_valid got=%0b exp=1", o_valid); end
    total++; if (o_data !== 8'sd8) begin bad++; $display("FAIL clr_second_data got=%0d exp=8", o_data); end
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL clr_drained got=%0b exp=0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_sat();
    test_backpressure();
    test_reset_mid();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
